// File: rtl/uart_apb_pkg.sv
// Shared UART register map, CTRL/STATUS bit positions and the TX arbiter FSM
// state encoding used by blocks that talk to the APB UART.
package uart_apb_pkg;

  localparam logic [31:0] UART_CTRL_ADDR   = 32'h00;
  localparam logic [31:0] UART_STATUS_ADDR = 32'h04;
  localparam logic [31:0] UART_TXDATA_ADDR = 32'h08;
  localparam logic [31:0] UART_RXDATA_ADDR = 32'h0C;
  localparam logic [31:0] UART_BAUDIV_ADDR = 32'h10;

  localparam int CTRL_TX_EN_BIT     = 0;
  localparam int CTRL_RX_EN_BIT     = 1;
  localparam int STATUS_TX_BUSY_BIT = 0;

  localparam logic [31:0] UART_CTRL_INIT =
    (32'h1 << CTRL_TX_EN_BIT) | (32'h1 << CTRL_RX_EN_BIT);

  typedef enum logic [2:0] {
    ST_INIT_SETUP,
    ST_INIT_ACCESS,
    ST_IDLE,
    ST_ARB,
    ST_POLL_SETUP,
    ST_POLL_ACCESS,
    ST_WR_SETUP,
    ST_WR_ACCESS
  } arb_state_t;

endpackage

// File: rtl/uart_apb_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: grants the first asserted request found
// searching upward from pointer, wrapping at NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] pointer,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDW = $clog2(NUM_REQ);

  logic           found;
  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, pointer} + (IDW+1)'(off);
      if (sum >= (IDW+1)'(NUM_REQ)) sum = sum - (IDW+1)'(NUM_REQ);
      idx = sum[IDW-1:0];
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/uart_apb_tx_arbiter.sv
// APB master sharing one UART between NUM_REQ byte producers: initialises CTRL,
// then round-robin grants a byte, polls STATUS until TX is free, writes TXDATA.
module uart_apb_tx_arbiter
  import uart_apb_pkg::*;
#(
  parameter int          NUM_REQ     = 4,
  parameter logic [31:0] CTRL_ADDR   = UART_CTRL_ADDR,
  parameter logic [31:0] STATUS_ADDR = UART_STATUS_ADDR,
  parameter logic [31:0] TXDATA_ADDR = UART_TXDATA_ADDR,
  parameter logic [31:0] CTRL_INIT   = UART_CTRL_INIT,
  parameter int          TX_BUSY_BIT = STATUS_TX_BUSY_BIT
) (
  input  logic                       PCLK,
  input  logic                       PRESETn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       init_done,
  output logic                       busy,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [31:0]                PADDR,
  output logic [31:0]                PWDATA,
  input  logic [31:0]                PRDATA,
  input  logic                       PREADY
);

  localparam int IDW = $clog2(NUM_REQ);

  arb_state_t     state, state_next;
  logic           run_en;
  logic [IDW-1:0] rr_ptr;
  logic [7:0]     hold;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDW-1:0]     arb_idx;
  logic               prdata_unused;

  assign prdata_unused = ^PRDATA;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req       (req_valid),
    .pointer   (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // run_en holds the APB outputs low for the first cycle after reset release,
  // so the INIT setup phase is a clean one-cycle PSEL=1/PENABLE=0 pulse while
  // PSEL is still forced low asynchronously whenever PRESETn is asserted.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_INIT_SETUP;
      run_en    <= 1'b0;
      init_done <= 1'b0;
      rr_ptr    <= '0;
      // NOTE: the hold byte is reset too, so an aborted transfer can never leak its data.
      hold      <= '0;
      grant_id  <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignment so every flop samples pre-edge values.
      state  <= state_next;
      run_en <= 1'b1;
      if (state == ST_INIT_ACCESS && PREADY) init_done <= 1'b1;
      if (state == ST_ARB && |req_valid) begin
        hold     <= req_data[{arb_idx, 3'b000} +: 8];
        grant_id <= arb_idx;
        rr_ptr   <= (arb_idx == IDW'(NUM_REQ - 1)) ? '0 : arb_idx + IDW'(1);
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_next = state;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PWRITE     = 1'b0;
    PADDR      = '0;
    PWDATA     = '0;
    case (state)
      ST_INIT_SETUP: begin
        if (run_en) begin
          PSEL       = 1'b1;
          PWRITE     = 1'b1;
          PADDR      = CTRL_ADDR;
          PWDATA     = CTRL_INIT;
          state_next = ST_INIT_ACCESS;
        end
      end
      ST_INIT_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = CTRL_ADDR;
        PWDATA  = CTRL_INIT;
        if (PREADY) state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (|req_valid) state_next = ST_ARB;
      end
      ST_ARB: begin
        state_next = (|req_valid) ? ST_POLL_SETUP : ST_IDLE;
      end
      ST_POLL_SETUP: begin
        PSEL       = 1'b1;
        PADDR      = STATUS_ADDR;
        state_next = ST_POLL_ACCESS;
      end
      ST_POLL_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PADDR   = STATUS_ADDR;
        if (PREADY) state_next = PRDATA[TX_BUSY_BIT] ? ST_POLL_SETUP : ST_WR_SETUP;
      end
      ST_WR_SETUP: begin
        PSEL       = 1'b1;
        PWRITE     = 1'b1;
        PADDR      = TXDATA_ADDR;
        PWDATA     = {24'h0, hold};
        state_next = ST_WR_ACCESS;
      end
      ST_WR_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = TXDATA_ADDR;
        PWDATA  = {24'h0, hold};
        if (PREADY) state_next = ST_IDLE;
      end
      default: state_next = ST_INIT_SETUP;
    endcase
  end

  assign req_ready = (state == ST_ARB) ? arb_grant : '0;
  assign busy      = state inside {ST_ARB, ST_POLL_SETUP, ST_POLL_ACCESS,
                                   ST_WR_SETUP, ST_WR_ACCESS};

endmodule

// File: tb/tb_uart_apb_tx_arbiter.sv
// Randomised bench for uart_apb_tx_arbiter: an APB UART slave model with wait
// states and busy polls, queued requesters, and a transaction-level reference.
module tb_uart_apb_tx_arbiter;

  localparam int N = 4;
  localparam logic [31:0] A_CTRL = 32'h00;
  localparam logic [31:0] A_STAT = 32'h04;
  localparam logic [31:0] A_TX   = 32'h08;

  logic         PCLK = 1'b0;
  logic         PRESETn = 1'b0;
  logic [N-1:0] req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_ready;
  logic [1:0]   grant_id;
  logic         init_done, busy;
  logic         PSEL, PENABLE, PWRITE;
  logic [31:0]  PADDR, PWDATA, PRDATA;
  logic         PREADY;

  uart_apb_tx_arbiter #(.NUM_REQ(N)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .init_done(init_done), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  gid;
    logic        init_before;
  } txn_t;

  txn_t log_q[$];
  txn_t exp_q[$];
  int   rdy_q[$];
  int   exp_g[$];

  // Requester byte queues, consumed on req_ready.
  logic [7:0] rq_mem [N][64];
  int rq_head [N];
  int rq_tail [N];
  int model_ptr = 0;

  // Slave configuration.
  int waits_cfg = 0;
  bit rnd_waits = 0;
  int busy_cfg  = 0;
  int busy_left = 0;

  task automatic push(input int r, input logic [7:0] d);
    rq_mem[r][rq_tail[r]] = d;
    rq_tail[r]++;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < N; i++) if (rq_head[i] < rq_tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Requester driver: pops on the ready pulse, updates after the edge.
  initial begin
    logic [N-1:0] rdy;
    req_valid = '0;
    req_data  = '0;
    forever begin
      @(negedge PCLK);
      rdy = req_ready;
      if (|req_ready) begin
        check("ready_onehot", 32'($onehot(req_ready)), 32'h1);
        for (int i = 0; i < N; i++) if (req_ready[i]) rdy_q.push_back(i);
      end
      @(posedge PCLK);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] && rq_head[i] < rq_tail[i]) rq_head[i]++;
        req_valid[i] = (rq_head[i] < rq_tail[i]);
        req_data[8*i +: 8] = rq_mem[i][rq_head[i] % 64];
      end
    end
  end

  // APB slave + protocol monitor.
  initial begin
    int wcnt, wcur;
    logic prev_psel, prev_wait, cap_write;
    logic [31:0] cap_addr, cap_wdata, rdata;
    txn_t t;
    wcnt = 0; wcur = 0; prev_psel = 0; prev_wait = 0;
    cap_write = 0; cap_addr = 0; cap_wdata = 0;
    PREADY = 1'b0;
    PRDATA = '0;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        PREADY = 1'b0; wcnt = 0; prev_psel = 0; prev_wait = 0;
        continue;
      end
      if (prev_wait) check("penable_held", {30'b0, PSEL, PENABLE}, 32'h3);
      if (PSEL && !PENABLE) begin
        cap_addr = PADDR; cap_wdata = PWDATA; cap_write = PWRITE;
        wcnt = 0;
        wcur = rnd_waits ? int'($urandom_range(0, waits_cfg)) : waits_cfg;
      end
      if (PSEL && PENABLE) begin
        check("setup_first", {31'b0, prev_psel}, 32'h1);
        check("stable_addr", PADDR, cap_addr);
        check("stable_write", {31'b0, PWRITE}, {31'b0, cap_write});
        if (cap_write) check("stable_wdata", PWDATA, cap_wdata);
        if (PADDR != A_CTRL) check("busy_in_xfer", {31'b0, busy}, 32'h1);
        if (wcnt < wcur) begin
          PREADY = 1'b0;
          wcnt++;
        end else begin
          PREADY = 1'b1;
          t.wr = PWRITE; t.addr = PADDR; t.gid = grant_id; t.init_before = init_done;
          if (PWRITE) begin
            t.data = PWDATA;
          end else begin
            rdata = $urandom;
            if (PADDR == A_STAT) begin
              if (busy_left > 0) begin rdata[0] = 1'b1; busy_left--; end
              else begin rdata[0] = 1'b0; busy_left = busy_cfg; end
            end
            PRDATA = rdata;
            t.data = rdata;
          end
          log_q.push_back(t);
        end
      end else begin
        PREADY = 1'b0;
      end
      prev_wait = PSEL && PENABLE && !PREADY;
      prev_psel = PSEL;
    end
  end

  // Reference: each granted byte costs busy_n busy polls, one free poll and a
  // TXDATA write; grant order is the valid requester closest above the pointer.
  task automatic run_scenario(input int busy_n, input int waits, input bit rnd);
    int h[N], tl[N];
    int ptr, best, bestd, d, n;
    txn_t e;
    waits_cfg = waits; rnd_waits = rnd; busy_cfg = busy_n; busy_left = busy_n;
    exp_q.delete(); exp_g.delete(); log_q.delete(); rdy_q.delete();
    for (int i = 0; i < N; i++) begin h[i] = rq_head[i]; tl[i] = rq_tail[i]; end
    ptr = model_ptr;
    forever begin
      best = -1; bestd = N;
      for (int g = 0; g < N; g++) begin
        if (h[g] < tl[g]) begin
          d = (g - ptr + N) % N;
          if (d < bestd) begin bestd = d; best = g; end
        end
      end
      if (best < 0) break;
      exp_g.push_back(best);
      for (int k = 0; k <= busy_n; k++) begin
        e.wr = 0; e.addr = A_STAT; e.data = (k < busy_n) ? 32'h1 : 32'h0;
        e.gid = 2'(best); e.init_before = 1'b1;
        exp_q.push_back(e);
      end
      e.wr = 1; e.addr = A_TX; e.data = {24'h0, rq_mem[best][h[best]]};
      e.gid = 2'(best); e.init_before = 1'b1;
      exp_q.push_back(e);
      h[best]++;
      ptr = (best + 1) % N;
    end
    model_ptr = ptr;
    n = exp_q.size();
    for (int c = 0; c < 4000; c++) begin
      @(negedge PCLK);
      if (log_q.size() >= n && !busy && queues_empty()) break;
    end
    repeat (4) @(negedge PCLK);
    check("txn_count", log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++) begin
      check("txn_wr", {31'b0, log_q[i].wr}, {31'b0, exp_q[i].wr});
      check("txn_addr", log_q[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) begin
        check("tx_data", log_q[i].data, exp_q[i].data);
        check("grant_id", {30'b0, log_q[i].gid}, {30'b0, exp_q[i].gid});
      end else begin
        check("poll_bit", {31'b0, log_q[i].data[0]}, {31'b0, exp_q[i].data[0]});
      end
    end
    check("grant_count", rdy_q.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < rdy_q.size(); i++)
      check("grant_order", rdy_q[i], exp_g[i]);
    check("idle_busy", {31'b0, busy}, 32'h0);
    for (int i = 0; i < N; i++) begin rq_head[i] = 0; rq_tail[i] = 0; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int cnt_ctrl, cnt_tx;
    PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_psel", {31'b0, PSEL}, 32'h0);
    check("rst_penable", {31'b0, PENABLE}, 32'h0);
    check("rst_pwrite", {31'b0, PWRITE}, 32'h0);
    check("rst_paddr", PADDR, 32'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_ready", {28'b0, req_ready}, 32'h0);
    check("rst_grant_id", {30'b0, grant_id}, 32'h0);
    check("rst_init_done", {31'b0, init_done}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);

    // Init write after release.
    PRESETn = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge PCLK);
      if (log_q.size() >= 1) break;
    end
    @(posedge PCLK); #1;
    check("init_txn_count", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      check("init_wr", {31'b0, log_q[0].wr}, 32'h1);
      check("init_addr", log_q[0].addr, A_CTRL);
      check("init_data", log_q[0].data, 32'h3);
      check("init_done_before", {31'b0, log_q[0].init_before}, 32'h0);
    end
    check("init_done_after", {31'b0, init_done}, 32'h1);
    log_q.delete();
    repeat (20) @(negedge PCLK);
    check("no_extra_apb", log_q.size(), 0);
    check("idle_busy0", {31'b0, busy}, 32'h0);

    // All four requesters continuously valid, two bytes each.
    for (int r = 0; r < N; r++) begin push(r, 8'h10 + 8'(r)); end
    for (int r = 0; r < N; r++) begin push(r, 8'h10 + 8'(r)); end
    run_scenario(0, 0, 0);

    // Single byte with two busy polls.
    push(0, 8'h5A);
    run_scenario(2, 0, 0);

    // Move the pointer to 2, then requesters 1 and 3 together.
    push(1, 8'($urandom));
    run_scenario(0, 0, 0);
    push(1, 8'h21);
    push(3, 8'h23);
    run_scenario(1, 0, 0);
    if (rdy_q.size() > 0) check("first_grant_ptr2", rdy_q[0], 3);

    // Three wait states on every access.
    for (int r = 0; r < N; r++) if ($urandom_range(0, 1) == 1 || r == 2) push(r, 8'($urandom));
    run_scenario(1, 3, 0);

    // Random rounds.
    for (int round = 0; round < 6; round++) begin
      for (int r = 0; r < N; r++) begin
        int k;
        k = $urandom_range(0, 3);
        for (int j = 0; j < k; j++) push(r, 8'($urandom));
      end
      run_scenario($urandom_range(0, 2), $urandom_range(0, 2), 1);
    end

    // Reset during WR_ACCESS.
    waits_cfg = 8; rnd_waits = 0; busy_cfg = 0; busy_left = 0;
    log_q.delete();
    push(2, 8'hEE);
    found = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge PCLK);
      if (PSEL && PENABLE && PWRITE && PADDR == A_TX) begin found = 1; break; end
    end
    check("wr_access_reached", {31'b0, found}, 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    check("abort_psel", {31'b0, PSEL}, 32'h0);
    check("abort_penable", {31'b0, PENABLE}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_init_done", {31'b0, init_done}, 32'h0);
    for (int i = 0; i < N; i++) begin rq_head[i] = 0; rq_tail[i] = 0; end
    waits_cfg = 0;
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    model_ptr = 0;
    repeat (40) @(negedge PCLK);
    cnt_ctrl = 0; cnt_tx = 0;
    foreach (log_q[i]) begin
      if (log_q[i].wr && log_q[i].addr == A_CTRL && log_q[i].data == 32'h3) cnt_ctrl++;
      if (log_q[i].wr && log_q[i].addr == A_TX) cnt_tx++;
    end
    check("reinit_ctrl_writes", cnt_ctrl, 1);
    check("aborted_byte_writes", cnt_tx, 0);
    check("reinit_done", {31'b0, init_done}, 32'h1);

    // Normal traffic after the abort.
    push(2, 8'h77);
    run_scenario(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_apb_tx_arbiter.md
Name: uart_apb_tx_arbiter

Overview:
APB master that shares the single APB UART between NUM_REQ byte-stream requesters. After reset it writes CTRL once to enable TX/RX. It then selects requesters round-robin, polls STATUS until the transmitter is free, and writes the granted byte to TXDATA. It sits between on-chip byte producers and the uart_apb_top slave port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
CTRL_ADDR, 32'h00, UART CTRL register address
STATUS_ADDR, 32'h04, UART STATUS register address
TXDATA_ADDR, 32'h08, UART TXDATA register address
CTRL_INIT, 32'h3, value written to CTRL after reset (TX_EN=1, RX_EN=1)
TX_BUSY_BIT, 0, STATUS bit index that is 1 while the transmitter cannot accept a byte

Ports:
PCLK  in  1  single clock, rising edge
PRESETn  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  byte for requester i in [8i+7:8i]
req_ready  out  NUM_REQ  one-hot, one-cycle pulse: byte i accepted
grant_id  out  $clog2(NUM_REQ)  index of the last granted requester
init_done  out  1  CTRL init write completed
busy  out  1  arbiter is serving a byte (ARB..WR_ACCESS)
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  32  APB address
PWDATA  out  32  APB write data
PRDATA  in  32  APB read data
PREADY  in  1  APB ready

Behaviour:
- Reset (async assert, sync release): state=INIT_SETUP; all outputs 0; rr pointer=0; hold register=0.
- APB protocol: SETUP state drives PSEL=1, PENABLE=0 for one cycle. ACCESS state drives PSEL=1, PENABLE=1 and holds until PREADY=1. PADDR, PWRITE and PWDATA stay stable across both phases. PRDATA is sampled on the ACCESS cycle with PREADY=1. PSEL=0 in IDLE/ARB.
- FSM states: INIT_SETUP, INIT_ACCESS, IDLE, ARB, POLL_SETUP, POLL_ACCESS, WR_SETUP, WR_ACCESS.
- INIT_SETUP -> INIT_ACCESS: write CTRL_ADDR with CTRL_INIT. On PREADY, set init_done=1 (stays 1 until reset) and go to IDLE.
- IDLE: if any req_valid, go to ARB; otherwise stay.
- ARB (one cycle): grant the first valid requester searching from the rr pointer upward, with wrap-around. Pulse req_ready[g]=1 this cycle and latch req_data[g] into the hold register. Set grant_id=g and pointer=(g+1) mod NUM_REQ. Go to POLL_SETUP. If req_valid has dropped to all zero by ARB, return to IDLE with no grant.
- POLL: read STATUS_ADDR. On the PREADY cycle, if PRDATA[TX_BUSY_BIT]=1 go to POLL_SETUP (re-poll, no idle gap); otherwise go to WR_SETUP.
- WR: write TXDATA_ADDR with PWDATA={24'h0, hold}. On PREADY go to IDLE.
- Minimum accepted-byte-to-TXDATA-complete latency is 5 cycles (ARB, 2 poll cycles, 2 write cycles) with zero wait states.
- Requester rule: req_data must be stable while req_valid=1. req_valid may drop only after req_ready.
- Simultaneous requests: exactly one grant per ARB. A requester that stays valid is served again only after every other valid requester has been served once, so there is no starvation.
- Wait states: any number of PREADY=0 cycles extends the ACCESS state. No timeout.
- Reset mid-transfer: PSEL and PENABLE drop asynchronously; the held byte is discarded and init is re-run.
- busy=1 in states ARB through WR_ACCESS; 0 otherwise.

Decomposition:
- Shared package uart_apb_pkg holds the register address constants (CTRL/STATUS/TXDATA/RXDATA/BAUDIV), CTRL bit positions, the STATUS TX_BUSY bit position, and the FSM state enum.
- Sub-module rr_arbiter (NUM_REQ; inputs req, pointer; outputs one-hot grant and grant index) is combinational and reused elsewhere. The FSM, APB drive and hold register live in the top block.

Test Plan:
- Reset, then release with no requests -> one APB write CTRL=0x3 with PSEL/PENABLE sequencing correct. init_done rises on that write's PREADY cycle, and no further APB activity occurs.
- Requester 0 sends 0x5A; STATUS returns busy=1 twice, then 0 -> req_ready[0] pulses once, 3 STATUS reads occur, then one TXDATA write with PWDATA=0x0000005A, and the FSM returns to IDLE.
- All 4 requesters are valid continuously with bytes 0x10..0x13 -> TXDATA writes occur in order 0x10, 0x11, 0x12, 0x13, 0x10 and grant_id follows 0,1,2,3,0.
- Requesters 1 and 3 are valid, pointer=2 -> requester 3 is served first, then 1.
- Slave inserts 3 PREADY=0 cycles on every access -> PADDR/PWDATA stay stable, PENABLE is held, and the data written is correct.
- Assert PRESETn=0 during WR_ACCESS -> PSEL=0 immediately. After release, CTRL is re-initialised and the aborted byte is never written.
